smi_frame_arbiter_x2: RTL and testbench

Two-way SMI frame arbiter. It shares one downstream SMI flit stream, such as the input of a flit width scaler or a link buffer, between two upstream SMI requesters. Arbitration is round-robin and happens only at frame boundaries, so frames are never interleaved. The output is registered, giving 1 flit cycle of latency, and stop/backpressure semantics follow the standard SMI handshake.

---
 rtl/smi_frame_arbiter_x2.sv | 68 ++++++
 tb/tb_smi_frame_arbiter_x2.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/smi_frame_arbiter_x2.sv
// smi_frame_arbiter_x2: two-way round-robin SMI arbiter that switches only at frame
// boundaries, with a registered output stage (1 flit cycle latency).
module smi_frame_arbiter_x2 #(
   parameter int FlitWidth = 4,
   parameter logic [7:0] EofcMask = 8'(2 * FlitWidth - 1)
) (
   input  logic                   clk,
   input  logic                   srst,
   input  logic                   smiInAReady,
   input  logic [7:0]             smiInAEofc,
   input  logic [FlitWidth*8-1:0] smiInAData,
   output logic                   smiInAStop,
   input  logic                   smiInBReady,
   input  logic [7:0]             smiInBEofc,
   input  logic [FlitWidth*8-1:0] smiInBData,
   output logic                   smiInBStop,
   output logic                   smiOutReady,
   output logic [7:0]             smiOutEofc,
   output logic [FlitWidth*8-1:0] smiOutData,
   input  logic                   smiOutStop,
   output logic [1:0]             arbGrant,
   output logic                   arbFrameActive
);
   localparam logic [1:0] IDLE = 2'd0, LOCK_A = 2'd1, LOCK_B = 2'd2;
   logic [1:0] state, curState;
   logic lastGrant, locked, selValid, selB, selReady, outHalt, accept;
   logic [7:0] selEofc;
   // While srst is high the stops already follow the idle rules with the output treated as empty
   assign curState = srst ? IDLE : state;
   assign locked = (curState == LOCK_A) | (curState == LOCK_B);
   assign outHalt = smiOutReady & smiOutStop & ~srst;
   always_comb begin
      selValid = locked | smiInAReady | smiInBReady;
      selB = curState == LOCK_B ? 1'b1 :
             curState == LOCK_A ? 1'b0 :
             (smiInAReady & smiInBReady) ? ~lastGrant : smiInBReady;
   end
   assign selReady = selB ? smiInBReady : smiInAReady;
   assign selEofc = selB ? smiInBEofc : smiInAEofc;
   assign accept = selValid & selReady & ~outHalt;
   assign smiInAStop = ~(selValid & ~selB) | outHalt;
   assign smiInBStop = ~(selValid & selB) | outHalt;
   assign arbGrant = selValid ? {selB, ~selB} : {lastGrant, ~lastGrant};
   assign arbFrameActive = curState != IDLE;
   always_ff @(posedge clk) begin
      if (srst) begin
         state <= IDLE;
         lastGrant <= 1'b1;
         smiOutReady <= 1'b0;
      end else begin
         if (!outHalt) smiOutReady <= selValid & selReady;
         if (accept) begin
            if (state == IDLE) begin
               lastGrant <= selB;
               state <= selEofc == 8'd0 ? (selB ? LOCK_B : LOCK_A) : IDLE;
            end else if (selEofc != 8'd0) begin
               state <= IDLE;
            end
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!outHalt) begin
         smiOutEofc <= selEofc & EofcMask;
         smiOutData <= selB ? smiInBData : smiInAData;
      end
   end
endmodule

// File: tb/tb_smi_frame_arbiter_x2.sv
// tb_smi_frame_arbiter_x2: directed scoreboard bench; expected output flits are queued by
// hand and a negedge monitor pops and compares every flit the arbiter transfers.
module tb_smi_frame_arbiter_x2;
   logic clk = 1'b0, srst = 1'b1;
   logic smiInAReady = 1'b0, smiInBReady = 1'b0, smiOutStop = 1'b0;
   logic [7:0] smiInAEofc = '0, smiInBEofc = '0, smiOutEofc;
   logic [31:0] smiInAData = '0, smiInBData = '0, smiOutData;
   logic smiInAStop, smiInBStop, smiOutReady, arbFrameActive;
   logic [1:0] arbGrant;
   logic [39:0] aQ[$], bQ[$], expQ[$];
   logic [39:0] got, want, prevOut;
   logic prevHalt = 1'b0;
   int checks = 0, errors = 0;

   smi_frame_arbiter_x2 #(.FlitWidth(4)) dut (
      .clk(clk), .srst(srst),
      .smiInAReady(smiInAReady), .smiInAEofc(smiInAEofc), .smiInAData(smiInAData), .smiInAStop(smiInAStop),
      .smiInBReady(smiInBReady), .smiInBEofc(smiInBEofc), .smiInBData(smiInBData), .smiInBStop(smiInBStop),
      .smiOutReady(smiOutReady), .smiOutEofc(smiOutEofc), .smiOutData(smiOutData), .smiOutStop(smiOutStop),
      .arbGrant(arbGrant), .arbFrameActive(arbFrameActive)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [39:0] act, input logic [39:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (prevHalt) chk("hold", {7'd0, smiOutReady, smiOutEofc, smiOutData}, {7'd0, 1'b1, prevOut});
      if (smiOutReady && smiOutStop) chk("stop_on_halt", {38'd0, smiInAStop, smiInBStop}, 40'd3);
      if (smiOutReady && !smiOutStop) begin
         got = {smiOutEofc, smiOutData};
         if (expQ.size() == 0) begin
            chk("unexpected_flit", got, 40'hDEAD);
         end else begin
            want = expQ.pop_front();
            chk("out_flit", got, want);
         end
      end
      prevHalt = smiOutReady & smiOutStop & ~srst;
      prevOut = {smiOutEofc, smiOutData};
   end

   task automatic drive();
      smiInAReady = aQ.size() > 0;
      smiInBReady = bQ.size() > 0;
      if (aQ.size() > 0) {smiInAEofc, smiInAData} = aQ[0];
      if (bQ.size() > 0) {smiInBEofc, smiInBData} = bQ[0];
   endtask

   task automatic tick();
      logic accA, accB;
      @(negedge clk);
      accA = smiInAReady & ~smiInAStop;
      accB = smiInBReady & ~smiInBStop;
      @(posedge clk);
      #1;
      if (accA) void'(aQ.pop_front());
      if (accB) void'(bQ.pop_front());
      drive();
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && (expQ.size() > 0 || aQ.size() > 0 || bQ.size() > 0); i++) tick();
      repeat (2) tick();
      chk("drain", 40'(expQ.size() + aQ.size() + bQ.size()), 40'd0);
   endtask

   task automatic doReset();
      srst = 1'b1;
      aQ.delete();
      bQ.delete();
      drive();
      repeat (2) @(posedge clk);
      #1 srst = 1'b0;
      #1;
   endtask

   initial begin
      doReset();
      chk("reset_state", {35'd0, smiOutReady, arbFrameActive, arbGrant, smiInAStop},
          {35'd0, 1'b0, 1'b0, 2'b10, 1'b1});
      chk("reset_bstop", 40'(smiInBStop), 40'd1);

      aQ = '{{8'h00, 32'h11}, {8'h00, 32'h22}, {8'h04, 32'h33}};
      expQ = '{{8'h00, 32'h11}, {8'h00, 32'h22}, {8'h04, 32'h33}};
      drive();
      #1;
      chk("t1_c1_active_bstop", {38'd0, arbFrameActive, smiInBStop}, 40'd1);
      tick();
      chk("t1_c2_active_bstop", {38'd0, arbFrameActive, smiInBStop}, 40'd3);
      tick();
      chk("t1_c3_active_bstop", {38'd0, arbFrameActive, smiInBStop}, 40'd3);
      tick();
      chk("t1_release", 40'(arbFrameActive), 40'd0);
      drain();

      doReset();
      aQ = '{{8'h00, 32'hA1}, {8'h05, 32'hA2}};
      bQ = '{{8'h00, 32'hB1}, {8'h06, 32'hB2}};
      expQ = '{{8'h00, 32'hA1}, {8'h05, 32'hA2}, {8'h00, 32'hB1}, {8'h06, 32'hB2}};
      drive();
      #1;
      chk("t2_tie_grant_a", {37'd0, arbGrant, smiInBStop}, {37'd0, 2'b01, 1'b1});
      tick();
      chk("t2_b_blocked", 40'(smiInBStop), 40'd1);
      tick();
      chk("t2_b_next", {37'd0, arbGrant, smiInBStop}, {37'd0, 2'b10, 1'b0});
      drain();

      for (int i = 0; i < 4; i++) begin
         aQ.push_back({8'h04, 32'hA0 + 32'(i)});
         bQ.push_back({8'h04, 32'hB0 + 32'(i)});
         expQ.push_back({8'h04, 32'hA0 + 32'(i)});
         expQ.push_back({8'h04, 32'hB0 + 32'(i)});
      end
      drive();
      repeat (8) tick();
      chk("t3_rate", 40'(aQ.size() + bQ.size()), 40'd0);
      drain();

      aQ = '{{8'h00, 32'hC1}, {8'h00, 32'hC2}, {8'h00, 32'hC3}, {8'h04, 32'hC4}};
      expQ = '{{8'h00, 32'hC1}, {8'h00, 32'hC2}, {8'h00, 32'hC3}, {8'h04, 32'hC4}};
      drive();
      tick();
      tick();
      smiOutStop = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("t4_astop", {38'd0, smiInAStop, smiOutReady}, 40'd3);
         tick();
      end
      chk("t4_held_data", 40'(smiOutData), 40'hC2);
      smiOutStop = 1'b0;
      drain();

      aQ = '{{8'h00, 32'hE0}, {8'hF4, 32'hE1}, {8'h08, 32'hE2}, {8'h00, 32'hE3}, {8'h08, 32'hE4}};
      expQ = '{{8'h00, 32'hE0}, {8'h04, 32'hE1}, {8'h00, 32'hE2}, {8'h00, 32'hE3}, {8'h00, 32'hE4}};
      drive();
      tick();
      chk("t5_lock", 40'(arbFrameActive), 40'd1);
      tick();
      chk("t5_f4_release", 40'(arbFrameActive), 40'd0);
      tick();
      chk("t5_08_single", 40'(arbFrameActive), 40'd0);
      tick();
      chk("t5_lock2", 40'(arbFrameActive), 40'd1);
      tick();
      chk("t5_08_release", 40'(arbFrameActive), 40'd0);
      drain();

      bQ = '{{8'h00, 32'hF0}, {8'h00, 32'hF1}};
      expQ = '{{8'h00, 32'hF0}};
      drive();
      tick();
      chk("t6_lock_b", {37'd0, arbFrameActive, arbGrant}, {37'd0, 1'b1, 2'b10});
      srst = 1'b1;
      bQ.delete();
      drive();
      tick();
      chk("t6_reset", {37'd0, smiOutReady, arbGrant}, {37'd0, 1'b0, 2'b10});
      chk("t6_idle", 40'(arbFrameActive), 40'd0);
      srst = 1'b0;
      aQ = '{{8'h04, 32'h5A}};
      bQ = '{{8'h04, 32'h5B}};
      expQ = '{{8'h04, 32'h5A}, {8'h04, 32'h5B}};
      drive();
      #1;
      chk("t6_tie_a", {37'd0, arbGrant, smiInBStop}, {37'd0, 2'b01, 1'b1});
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
